tick_event_sequencer: RTL and testbench

//  Consumes the periodic tick pulse (sig), error (err) and in-window flag (flg) produced by the

---
 rtl/tick_event_sequencer.sv | 120 ++++++++++++
 tb/tb_tick_event_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tick_event_sequencer.sv
// Divides the upstream tick stream into events, hands each event to a consumer over req/ack,
// and latches into FAULT on upstream error, out-of-window tick or tick gap timeout.
module tick_event_sequencer #(
    parameter int DIV   = 4,
    parameter int TMAX  = 12502,
    parameter int GBITS = 14,
    parameter int EBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             tick_err,
    input  logic             tick_win,
    input  logic             ack,
    output logic             req,
    output logic [EBITS-1:0] evt_cnt,
    output logic             overrun,
    output logic             timeout,
    output logic             fault,
    output logic [1:0]       state
);
    localparam int TBITS = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PEND  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t           cur, nxt;
    logic [TBITS-1:0] tick_cnt, tcnt_d;
    logic [GBITS-1:0] gap_cnt, gap_d;
    logic             req_d, ovr_d, to_d, fault_d;
    logic [EBITS-1:0] evt_d;
    logic             active, evt, gap_hit, flt;

    always_comb begin
        active  = (cur == RUN) || (cur == PEND);
        evt     = tick && (tick_cnt == TBITS'(DIV - 1));
        gap_hit = !tick && (gap_cnt == GBITS'(TMAX - 1));
        flt     = active && (tick_err || (tick && !tick_win) || gap_hit);
        // timeout only reports a gap fault that was not preempted by tick_err
        to_d    = active && !tick_err && gap_hit;

        nxt    = cur;
        req_d  = req;
        evt_d  = evt_cnt;
        ovr_d  = overrun;
        tcnt_d = tick_cnt;

        if (tick)
            gap_d = '0;
        else if (gap_cnt == GBITS'(TMAX))
            gap_d = gap_cnt;
        else
            gap_d = gap_cnt + 1'b1;

        if (cur != FAULT && !flt && tick)
            tcnt_d = evt ? '0 : tick_cnt + 1'b1;

        case (cur)
            IDLE: begin
                if (tick) nxt = RUN;
            end
            RUN: begin
                if (evt) begin
                    req_d = 1'b1;
                    evt_d = evt_cnt + 1'b1;
                    nxt   = PEND;
                end
            end
            PEND: begin
                if (evt) begin
                    if (ack) evt_d = evt_cnt + 1'b1;
                    else     ovr_d = 1'b1;
                end else if (ack) begin
                    req_d = 1'b0;
                    nxt   = RUN;
                end
            end
            default: ;
        endcase

        // a fault overrides any event or ack seen in the same cycle
        if (flt) begin
            nxt   = FAULT;
            req_d = 1'b0;
            evt_d = evt_cnt;
            ovr_d = overrun;
        end

        fault_d = (nxt == FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= IDLE;
            tick_cnt <= '0;
            gap_cnt  <= '0;
            req      <= 1'b0;
            evt_cnt  <= '0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
            fault    <= 1'b0;
        end else begin
            cur      <= nxt;
            tick_cnt <= tcnt_d;
            gap_cnt  <= gap_d;
            req      <= req_d;
            evt_cnt  <= evt_d;
            overrun  <= ovr_d;
            timeout  <= to_d;
            fault    <= fault_d;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_tick_event_sequencer.sv
// Bench for tick_event_sequencer: vector table, directed corner sequences and random traffic
// checked every cycle against a tick-count / timestamp reference model.
module tb_tick_event_sequencer;
    localparam int DIV   = 4;
    localparam int TMAX  = 10;
    localparam int GBITS = 4;
    localparam int EBITS = 3;

    logic             clk = 1'b0;
    logic             rst, tick, tick_err, tick_win, ack;
    logic             req, overrun, timeout, fault;
    logic [EBITS-1:0] evt_cnt;
    logic [1:0]       state;

    tick_event_sequencer #(.DIV(DIV), .TMAX(TMAX), .GBITS(GBITS), .EBITS(EBITS)) dut (
        .clk(clk), .rst(rst), .tick(tick), .tick_err(tick_err), .tick_win(tick_win),
        .ack(ack), .req(req), .evt_cnt(evt_cnt), .overrun(overrun), .timeout(timeout),
        .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: total ticks accepted since reset and timestamp of the last tick
    int m_state, m_evt, m_ticks, m_last, cyc;
    bit m_req, m_ovr, m_to, m_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit t, input bit e, input bit w, input bit a);
        bit active, flt, ev;
        cyc++;
        m_to = 0;
        if (r) begin
            m_state = 0; m_req = 0; m_evt = 0; m_ovr = 0; m_fault = 0;
            m_ticks = 0; m_last = cyc;
            return;
        end
        if (m_state == 3) return;
        active = (m_state == 1 || m_state == 2);
        flt = 0;
        if (active) begin
            if (e) flt = 1;
            else if (t && !w) flt = 1;
            else if (!t && (cyc - m_last) == TMAX) begin flt = 1; m_to = 1; end
        end
        if (flt) begin
            m_state = 3; m_fault = 1; m_req = 0;
            return;
        end
        ev = 0;
        if (t) begin
            m_last = cyc;
            m_ticks++;
            ev = (m_ticks % DIV) == 0;
        end
        case (m_state)
            0: if (t) m_state = 1;
            1: if (ev) begin m_req = 1; m_evt = (m_evt + 1) % (1 << EBITS); m_state = 2; end
            2: begin
                if (ev) begin
                    if (a) m_evt = (m_evt + 1) % (1 << EBITS);
                    else   m_ovr = 1;
                end else if (a) begin
                    m_req = 0; m_state = 1;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [8:0] pack(input logic q, input logic [2:0] ev, input logic [1:0] st,
                                        input logic o, input logic to, input logic f);
        return {q, ev, st, o, to, f};
    endfunction

    task automatic drive(input bit r, input bit t, input bit e, input bit w, input bit a);
        rst = r; tick = t; tick_err = e; tick_win = w; ack = a;
        @(posedge clk);
        model_step(r, t, e, w, a);
        #1;
        check("cycle{req,evt,state,ovr,to,fault}",
              32'(pack(req, evt_cnt, state, overrun, timeout, fault)),
              32'(pack(m_req, 3'(m_evt), 2'(m_state), m_ovr, m_to, m_fault)));
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 1, 0);
    endtask

    typedef struct {
        bit       r, t, e, w, a;
        bit       q;
        bit [2:0] ev;
        bit [1:0] st;
        bit       o, to, f;
    } vec_t;

    vec_t vt[13];

    initial begin
        int tdelay, age;
        bit av;

        rst = 1; tick = 0; tick_err = 0; tick_win = 1; ack = 0;
        cyc = 0; m_state = 0; m_evt = 0; m_ticks = 0; m_last = 0;
        m_req = 0; m_ovr = 0; m_to = 0; m_fault = 0;

        //         r  t  e  w  a   q  ev st o to f
        vt[0]  = '{1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 1, 0,  0, 0, 1, 0, 0, 0};
        vt[2]  = '{0, 1, 0, 1, 0,  0, 0, 1, 0, 0, 0};
        vt[3]  = '{0, 1, 0, 1, 0,  0, 0, 1, 0, 0, 0};
        vt[4]  = '{0, 1, 0, 1, 0,  1, 1, 2, 0, 0, 0};
        vt[5]  = '{0, 0, 0, 1, 1,  0, 1, 1, 0, 0, 0};
        vt[6]  = '{0, 1, 0, 1, 0,  0, 1, 1, 0, 0, 0};
        vt[7]  = '{0, 1, 0, 1, 0,  0, 1, 1, 0, 0, 0};
        vt[8]  = '{0, 1, 0, 1, 0,  0, 1, 1, 0, 0, 0};
        vt[9]  = '{0, 1, 0, 1, 0,  1, 2, 2, 0, 0, 0};
        vt[10] = '{0, 1, 0, 1, 0,  1, 2, 2, 0, 0, 0};
        vt[11] = '{0, 0, 1, 1, 0,  0, 2, 3, 0, 0, 1};
        vt[12] = '{0, 1, 0, 1, 1,  0, 2, 3, 0, 0, 1};

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].r, vt[i].t, vt[i].e, vt[i].w, vt[i].a);
            check($sformatf("vec%0d", i), 32'(pack(req, evt_cnt, state, overrun, timeout, fault)),
                  32'(pack(vt[i].q, vt[i].ev, vt[i].st, vt[i].o, vt[i].to, vt[i].f)));
        end

        // tick every 8 cycles, ack two cycles after req rises
        do_reset();
        age = 0;
        for (int i = 0; i < 96; i++) begin
            av = m_req && (age == 2);
            drive(0, (i % 8) == 0, 0, 1, av);
            age = m_req ? age + 1 : 0;
            if (i == 24) check("t1_req_after_tick4", 32'(req), 32'd1);
        end
        check("t1_evt", 32'(evt_cnt), 32'd3);
        check("t1_fault", 32'(fault), 32'd0);

        // no ack: second event is lost
        do_reset();
        for (int i = 0; i < 60; i++) drive(0, (i % 8) == 0, 0, 1, 0);
        check("t2_ovr", 32'(overrun), 32'd1);
        check("t2_evt", 32'(evt_cnt), 32'd1);
        check("t2_req", 32'(req), 32'd1);

        // ack coincides with tick 8
        do_reset();
        for (int i = 0; i <= 56; i++) drive(0, (i % 8) == 0, 0, 1, i == 56);
        check("t3_req", 32'(req), 32'd1);
        check("t3_evt", 32'(evt_cnt), 32'd2);
        check("t3_ovr", 32'(overrun), 32'd0);

        // gap timeout
        do_reset();
        drive(0, 1, 0, 1, 0);
        tdelay = 0;
        for (int j = 1; j <= 20; j++) begin
            drive(0, 0, 0, 1, 0);
            if (timeout && tdelay == 0) tdelay = j;
        end
        check("t4_timeout_delay", 32'(tdelay), 32'd10);
        check("t4_state", 32'(state), 32'd3);
        check("t4_req", 32'(req), 32'd0);
        for (int j = 0; j < 12; j++) drive(0, 1, 0, 1, 1);
        check("t4_absorb", 32'(state), 32'd3);

        // window and error faults, ignored while idle
        do_reset();
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 1, 0, 0);
        check("t5_idle_err", 32'(state), 32'd0);
        drive(0, 1, 0, 0, 0);
        check("t5_idle_win", 32'(state), 32'd1);
        drive(0, 1, 0, 0, 0);
        check("t5_win_fault", 32'(state), 32'd3);
        do_reset();
        drive(0, 1, 0, 1, 0);
        drive(0, 0, 1, 1, 0);
        check("t5_err_fault", 32'(state), 32'd3);

        // reset mid-handshake, then wrap the event counter
        do_reset();
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 1, 0);
        check("t6_req_before", 32'(req), 32'd1);
        do_reset();
        check("t6_rst", 32'(pack(req, evt_cnt, state, overrun, timeout, fault)), 32'h0);
        for (int i = 0; i < 72; i++) begin
            drive(0, (i % 2) == 0, 0, 1, 1);
            if (i == 62) check("t6_wrap0", 32'(evt_cnt), 32'd0);
        end
        check("t6_evt9", 32'(evt_cnt), 32'd1);

        // random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 149) == 0, $urandom_range(0, 39) != 0,
                  $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
